icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 The block SHALL have parameters: WNUM, default 16, words per cache line; WBKSZ, default 4, words per write beat (WNUM multiple of WBKSZ); LAW, default 10, line-address width.
REQ-002 The block SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 The block SHALL have port: rst_n  in  1  synchronous active-low reset.
REQ-004 The block SHALL have port: miss_valid  in  1  refill request from the fetch stage.
REQ-005 The block SHALL have port: miss_ready  out  1  refill request accepted.
REQ-006 The block SHALL have port: miss_paddr  in  32  physical address of the missing line.
REQ-007 The block SHALL have port: miss_laddr  in  LAW  target cache line index.
REQ-008 The block SHALL have port: flush  in  1  abort the current refill.
REQ-009 The block SHALL have port: mem_req_valid  out  1  memory read request.
REQ-010 The block SHALL have port: mem_req_ready  in  1  memory accepts the request.
REQ-011 The block SHALL have port: mem_req_addr  out  32  line-aligned request address.
REQ-012 The block SHALL have port: mem_resp_valid  in  1  response beat valid, no backpressure.
REQ-013 The block SHALL have port: mem_resp_data  in  WBKSZ*32  beat data, word 0 in the LSBs.
REQ-014 The block SHALL have port: mem_resp_last  in  1  final beat marker.
REQ-015 The block SHALL have port: wr_en  out  1  data-array write enable.
REQ-016 The block SHALL have port: wr_laddr  out  LAW  line address written.
REQ-017 The block SHALL have port: wr_waddr  out  log2(WNUM)  first word of the beat.
REQ-018 The block SHALL have port: wr_data  out  WBKSZ x 32  beat words.
REQ-019 The block SHALL have port: refill_done  out  1  one-cycle pulse, line complete.
REQ-020 The block SHALL have port: refill_err  out  1  one-cycle pulse, last-marker mismatch.

Function
REQ-021 The block SHALL implement the states IDLE, REQ, FILL, DRAIN and DONE, with NBEAT = WNUM/WBKSZ.
REQ-022 In IDLE the block SHALL drive miss_ready=1; when miss_valid is high, it SHALL latch miss_paddr and miss_laddr and enter REQ.
REQ-023 In all other states the block SHALL drive miss_ready=0.
REQ-024 In REQ the block SHALL drive mem_req_valid=1 and mem_req_addr = latched paddr with bits [log2(WNUM*4)-1:0] forced to 0.
REQ-025 In REQ, on mem_req_ready the block SHALL enter FILL with the beat counter at 0.
REQ-026 In REQ, flush SHALL take priority over mem_req_ready: the block SHALL return to IDLE and issue no request.
REQ-027 In FILL, a beat accepted at cycle t SHALL produce, at t+1 (registered):
- wr_en=1
- wr_laddr = latched laddr
- wr_waddr = beat*WBKSZ
- wr_data = the beat words
REQ-028 In FILL, the beat counter SHALL increment by 1 per beat.
REQ-029 wr_en SHALL be 0 in any cycle that has no beat from the previous cycle.
REQ-030 Gaps between beats SHALL be tolerated with no timeout.
REQ-031 When beat NBEAT-1 is accepted at cycle t, the block SHALL be in DONE at t+1, assert refill_done at t+1 (coincident with the final wr_en), and be in IDLE at t+2.
REQ-032 A mismatch SHALL be recorded when mem_resp_last=1 on a beat other than NBEAT-1, or mem_resp_last=0 on beat NBEAT-1.
REQ-033 On a recorded mismatch the block SHALL still write all beats and SHALL assert refill_err together with refill_done.
REQ-034 The beat count alone SHALL end the line.
REQ-035 On flush in FILL, the block SHALL enter DRAIN, and any write registered from a beat in the flush cycle SHALL still be issued.
REQ-036 In DRAIN the block SHALL keep counting beats, suppress wr_en, and return to IDLE after beat NBEAT-1 without refill_done or refill_err.
REQ-037 Flush in IDLE, DONE or DRAIN SHALL be ignored.
REQ-038 mem_resp_valid in IDLE or REQ SHALL be ignored with no write.
REQ-039 The beat counter SHALL be log2(NBEAT) bits wide and SHALL be cleared on entry to FILL.

Reset
REQ-040 When rst_n=0 at a rising edge, the block SHALL:
- enter IDLE
- clear the beat counter and mismatch flag
- drive wr_en=0, mem_req_valid=0, refill_done=0, refill_err=0 in the following cycle
REQ-041 Reset SHALL take effect mid-refill with no further writes.
REQ-042 miss_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-043 wr_laddr, wr_waddr and wr_data SHALL be reset to 0.

Verification
REQ-044 Basic refill: miss paddr=0x0000_1234, laddr=5, ready immediate, 4 back-to-back beats, last on beat 3 -> mem_req_addr=0x0000_1200; wr_en on 4 consecutive cycles with waddr 0,4,8,12, laddr 5; refill_done on the 4th write cycle; miss_ready=1 the next cycle.
REQ-045 Gapped beats plus request backpressure: mem_req_ready low for 3 cycles, 2 idle cycles between beats -> request held stable; exactly 4 writes, each one cycle after its beat; no spurious wr_en.
REQ-046 Last mismatch: mem_resp_last on beat 1 -> 4 writes; refill_done and refill_err both pulse once.
REQ-047 Flush during FILL after beat 1 -> writes for beats 0 and 1 only; beats 2 and 3 drained without write; no done; IDLE after beat 3.
REQ-048 Flush in REQ and reset mid-FILL -> no request issued, back in IDLE; after reset, wr_en=0 and miss_ready=1, and a stray mem_resp_valid causes no write.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: issues one line-aligned memory read,
// writes each returned beat into the data array, and reports completion/errors.
module icache_refill #(
  parameter int WNUM  = 16,
  parameter int WBKSZ = 4,
  parameter int LAW   = 10,
  localparam int WW   = (WNUM > 1) ? $clog2(WNUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [31:0]           miss_paddr,
  input  logic [LAW-1:0]        miss_laddr,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [WBKSZ*32-1:0]   mem_resp_data,
  input  logic                  mem_resp_last,
  output logic                  wr_en,
  output logic [LAW-1:0]        wr_laddr,
  output logic [WW-1:0]         wr_waddr,
  output logic [WBKSZ*32-1:0]   wr_data,
  output logic                  refill_done,
  output logic                  refill_err
);

  localparam int NBEAT = WNUM / WBKSZ;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int OFFW  = $clog2(WNUM * 4);
  localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFFW) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEAT - 1);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} state_t;

  state_t              r_state;
  logic [31:0]         r_paddr;
  logic [LAW-1:0]      r_laddr;
  logic [BW-1:0]       r_beat;
  logic                r_mismatch;
  logic                r_wr_en;
  logic [LAW-1:0]      r_wr_laddr;
  logic [WW-1:0]       r_wr_waddr;
  logic [WBKSZ*32-1:0] r_wr_data;
  logic                r_done;
  logic                r_err;

  logic w_beat_last;
  logic w_last_bad;

  assign w_beat_last = (r_beat == LAST_BEAT);
  // The last marker must appear on exactly the final beat; the count still ends the line.
  assign w_last_bad  = (mem_resp_last != w_beat_last);

  assign miss_ready    = (r_state == IDLE);
  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = r_paddr;
  assign wr_en         = r_wr_en;
  assign wr_laddr      = r_wr_laddr;
  assign wr_waddr      = r_wr_waddr;
  assign wr_data       = r_wr_data;
  assign refill_done   = r_done;
  assign refill_err    = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_paddr    <= '0;
      r_laddr    <= '0;
      r_beat     <= '0;
      r_mismatch <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_laddr <= '0;
      r_wr_waddr <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (miss_valid) begin
            r_paddr <= miss_paddr & ALIGN_MASK;
            r_laddr <= miss_laddr;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (mem_req_ready) begin
            r_beat     <= '0;
            r_mismatch <= 1'b0;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (mem_resp_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_laddr <= r_laddr;
            r_wr_waddr <= WW'(r_beat) * WW'(WBKSZ);
            r_wr_data  <= mem_resp_data;
            r_beat     <= r_beat + BW'(1);
            if (w_beat_last) begin
              // A flush arriving with the final beat keeps the write but skips completion.
              if (flush) begin
                r_state <= IDLE;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_err   <= r_mismatch | w_last_bad;
              end
            end else begin
              r_mismatch <= r_mismatch | w_last_bad;
              if (flush) r_state <= DRAIN;
            end
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_resp_valid) begin
            r_beat <= r_beat + BW'(1);
            if (w_beat_last) r_state <= IDLE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: a driver pushes expected requests, writes
// and completions into queues; a negedge monitor pops and compares them.
module tb_icache_refill;
  localparam int WNUM = 16, WBKSZ = 4, LAW = 10, NBEAT = WNUM / WBKSZ;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                miss_valid = 1'b0;
  logic                miss_ready;
  logic [31:0]         miss_paddr = '0;
  logic [LAW-1:0]      miss_laddr = '0;
  logic                flush = 1'b0;
  logic                mem_req_valid;
  logic                mem_req_ready = 1'b0;
  logic [31:0]         mem_req_addr;
  logic                mem_resp_valid = 1'b0;
  logic [WBKSZ*32-1:0] mem_resp_data = '0;
  logic                mem_resp_last = 1'b0;
  logic                wr_en;
  logic [LAW-1:0]      wr_laddr;
  logic [3:0]          wr_waddr;
  logic [WBKSZ*32-1:0] wr_data;
  logic                refill_done;
  logic                refill_err;

  icache_refill #(.WNUM(WNUM), .WBKSZ(WBKSZ), .LAW(LAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_paddr(miss_paddr), .miss_laddr(miss_laddr), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
    .wr_en(wr_en), .wr_laddr(wr_laddr), .wr_waddr(wr_waddr), .wr_data(wr_data),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [LAW-1:0] laddr;
    logic [3:0]     waddr;
    logic [127:0]   data;
  } wr_t;
  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  wr_t         exp_wr[$];
  done_t       exp_done[$];
  logic [31:0] exp_req[$];

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares DUT activity against the scoreboard queues.
  always @(negedge clk) begin
    if (mem_req_valid && exp_req.size() > 0) chk("req_addr", mem_req_addr, exp_req[0]);
    if (mem_req_valid && mem_req_ready && !flush) begin
      if (exp_req.size() == 0) chk("req_unexpected", mem_req_valid, 1'b0);
      else void'(exp_req.pop_front());
    end
    if (wr_en) begin
      if (exp_wr.size() == 0) chk("wr_en_unexpected", wr_en, 1'b0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_laddr", wr_laddr, e.laddr);
        chk("wr_waddr", wr_waddr, e.waddr);
        chk("wr_data", wr_data, e.data);
        $display("write cyc=%0d laddr=%0d waddr=%0d data=%h", cyc, wr_laddr, wr_waddr, wr_data);
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      chk("wr_en_missing", wr_en, 1'b1);
      void'(exp_wr.pop_front());
    end
    if (refill_done) begin
      if (exp_done.size() == 0) chk("done_unexpected", refill_done, 1'b0);
      else begin
        done_t d;
        d = exp_done.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("refill_err", refill_err, d.err);
        $display("done  cyc=%0d err=%0d", cyc, refill_err);
      end
    end else begin
      if (refill_err) chk("err_without_done", refill_err, 1'b0);
      if (exp_done.size() > 0 && exp_done[0].cyc <= cyc) begin
        chk("done_missing", refill_done, 1'b1);
        void'(exp_done.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] pa, input logic [LAW-1:0] la, input int rdly,
                        input int gap_lo, input int gap_hi, input int flush_beat,
                        input int bad_beat, input bit flush_req);
    int t;
    bit drain;
    bit err;
    logic [127:0] d;
    wr_t w;
    done_t dn;
    drain = 1'b0;
    err = 1'b0;
    t = 0;
    while (!miss_ready && t < 20) begin
      step();
      t++;
    end
    chk("miss_ready_idle", miss_ready, 1'b1);
    miss_valid = 1'b1;
    miss_paddr = pa;
    miss_laddr = la;
    step();
    miss_valid = 1'b0;
    miss_paddr = $urandom;
    miss_laddr = LAW'($urandom);
    chk("miss_ready_busy", miss_ready, 1'b0);
    $display("miss  cyc=%0d paddr=%h laddr=%0d flush_req=%0d flush_beat=%0d bad_beat=%0d",
             cyc, pa, la, flush_req, flush_beat, bad_beat);
    if (flush_req) begin
      flush = 1'b1;
      mem_req_ready = 1'b1;
      step();
      flush = 1'b0;
      mem_req_ready = 1'b0;
      chk("idle_after_req_flush", miss_ready, 1'b1);
      return;
    end
    exp_req.push_back(pa & 32'hFFFF_FFC0);
    for (int i = 0; i < rdly; i++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_last = 1'($urandom_range(0, 1));
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    mem_resp_valid = 1'b0;
    mem_resp_last = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < NBEAT; b++) begin
      repeat ($urandom_range(gap_lo, gap_hi)) begin
        if (drain) flush = 1'($urandom_range(0, 1));
        step();
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp_valid = 1'b1;
      mem_resp_data = d;
      mem_resp_last = (b == NBEAT - 1) ^ (b == bad_beat);
      if (b == bad_beat) err = 1'b1;
      flush = (b == flush_beat) || (drain && $urandom_range(0, 1) == 1);
      if (!drain) begin
        w.cyc = cyc + 1;
        w.laddr = la;
        w.waddr = 4'(b * WBKSZ);
        w.data = d;
        exp_wr.push_back(w);
        if (b == NBEAT - 1) begin
          dn.cyc = cyc + 1;
          dn.err = err;
          exp_done.push_back(dn);
        end
      end
      if (b == flush_beat) drain = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_last = 1'b0;
      flush = 1'b0;
    end
    if (!drain) begin
      chk("busy_in_done", miss_ready, 1'b0);
      flush = 1'($urandom_range(0, 1));
      step();
      flush = 1'b0;
      chk("ready_after_done", miss_ready, 1'b1);
    end else begin
      chk("ready_after_drain", miss_ready, 1'b1);
    end
  endtask

  initial begin
    logic [127:0] d;
    wr_t w;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_done", refill_done, 1'b0);
    chk("rst_err", refill_err, 1'b0);
    chk("rst_wr_laddr", wr_laddr, '0);
    chk("rst_wr_waddr", wr_waddr, '0);
    chk("rst_wr_data", wr_data, '0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", miss_ready, 1'b1);

    refill(32'h0000_1234, 10'd5, 0, 0, 0, -1, -1, 1'b0);
    refill(32'h0000_ABCD, 10'd9, 3, 2, 2, -1, -1, 1'b0);
    refill(32'h8000_0044, 10'd17, 1, 0, 1, -1, 1, 1'b0);
    refill(32'h0001_0FFF, 10'd100, 0, 0, 1, 1, -1, 1'b0);
    refill(32'h0000_2000, 10'd3, 0, 0, 0, -1, -1, 1'b1);

    // Reset in the middle of a fill: the beat coincident with reset must not be written.
    miss_valid = 1'b1;
    miss_paddr = 32'h0000_5678;
    miss_laddr = 10'd7;
    step();
    miss_valid = 1'b0;
    exp_req.push_back(32'h0000_5640);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp_valid = 1'b1;
      mem_resp_data = d;
      w.cyc = cyc + 1;
      w.laddr = 10'd7;
      w.waddr = 4'(b * WBKSZ);
      w.data = d;
      exp_wr.push_back(w);
      step();
    end
    mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    step();
    mem_resp_valid = 1'b0;
    rst_n = 1'b1;
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    step();
    chk("midrst_ready", miss_ready, 1'b1);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    step();
    chk("stray_beat_no_write", wr_en, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int fb;
      int bb;
      fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBEAT - 2)) : -1;
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBEAT - 1)) : -1;
      refill($urandom, LAW'($urandom), int'($urandom_range(0, 3)), 0, 2, fb, bb,
             $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) begin
        flush = 1'($urandom_range(0, 1));
        mem_resp_valid = 1'($urandom_range(0, 1));
        step();
      end
      flush = 1'b0;
      mem_resp_valid = 1'b0;
    end

    repeat (4) step();
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_done_drained", exp_done.size(), 0);
    chk("exp_req_drained", exp_req.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
